// File: rtl/fir_tap_sequencer_pkg.sv
// Shared sizing and FSM state encoding for the FIR tap sequencer and its delay line.
package fir_tap_sequencer_pkg;

    localparam int unsigned FIR_NTAPS = 8;
    localparam int unsigned FIR_DW    = 16;
    localparam int unsigned FIR_ACCW  = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        SETTLE = 2'd2,
        OUT    = 2'd3
    } fir_state_e;

endpackage

// File: rtl/fir_tap_sequencer_delay_line.sv
// Circular sample history: one write per accepted sample, combinational read of the sample k taps back.
module fir_delay_line
    import fir_tap_sequencer_pkg::*;
#(
    parameter int unsigned NTAPS = FIR_NTAPS,
    parameter int unsigned DW    = FIR_DW,
    parameter int unsigned AW    = $clog2(NTAPS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] rd_off,
    output logic [DW-1:0] rd_data_c
);

    logic [DW-1:0] mem_q [NTAPS];
    logic [DW-1:0] mem_d [NTAPS];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] newest_q, newest_d;

    always_comb begin
        mem_d    = mem_q;
        wptr_d   = wptr_q;
        newest_d = newest_q;
        if (we) begin
            mem_d[wptr_q] = wdata;
            newest_d      = wptr_q;
            wptr_d        = AW'(wptr_q + 1'b1);
        end
    end

    // AW-bit subtraction wraps modulo NTAPS (power of two)
    assign rd_data_c = mem_q[AW'(newest_q - rd_off)];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NTAPS); i++) mem_q[i] <= '0;
            wptr_q   <= '0;
            newest_q <= '0;
        end else begin
            mem_q    <= mem_d;
            wptr_q   <= wptr_d;
            newest_q <= newest_d;
        end
    end

endmodule

// File: rtl/fir_tap_sequencer.sv
// Feeds NTAPS (sample, coefficient) pairs per input sample into an accumulate-only MAC
// and reports the accumulator delta across the run as the filter output.
module fir_tap_sequencer
    import fir_tap_sequencer_pkg::*;
#(
    parameter int unsigned NTAPS = FIR_NTAPS,
    parameter int unsigned DW    = FIR_DW,
    parameter int unsigned AW    = $clog2(NTAPS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic [DW-1:0]       in_data,
    output logic                in_ready,
    input  logic                coef_we,
    input  logic [AW-1:0]       coef_addr,
    input  logic [DW-1:0]       coef_wdata,
    output logic [DW-1:0]       mac_a,
    output logic [DW-1:0]       mac_b,
    output logic                mac_en,
    input  logic [FIR_ACCW-1:0] mac_acc,
    output logic                out_valid,
    output logic [FIR_ACCW-1:0] out_data,
    input  logic                out_ready
);

    localparam int unsigned ACCW = FIR_ACCW;

    fir_state_e    state_q, state_d;
    logic [AW-1:0] k_q, k_d;
    logic [ACCW-1:0] base_q, base_d;
    logic [ACCW-1:0] out_data_q, out_data_d;
    logic          out_valid_q, out_valid_d;
    logic          in_ready_q, in_ready_d;
    logic          mac_en_q, mac_en_d;
    logic [DW-1:0] mac_a_q, mac_a_d;
    logic [DW-1:0] mac_b_q, mac_b_d;
    logic [DW-1:0] coef_q [NTAPS];
    logic [DW-1:0] coef_d [NTAPS];

    logic          accept_c;
    logic          k_last_c;
    logic [DW-1:0] tap_sample_c;

    assign accept_c = in_valid && (state_q == IDLE);
    assign k_last_c = (k_q == AW'(NTAPS - 1));

    fir_delay_line #(
        .NTAPS (NTAPS),
        .DW    (DW),
        .AW    (AW)
    ) u_delay (
        .clk       (clk),
        .rst       (rst),
        .we        (accept_c),
        .wdata     (in_data),
        .rd_off    (k_q),
        .rd_data_c (tap_sample_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // SETTLE waits for the registered MAC operands to drain so mac_acc holds the full sum
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept_c)  state_d = RUN;
            RUN:     if (k_last_c)  state_d = SETTLE;
            SETTLE:  if (!mac_en_q) state_d = OUT;
            OUT:     if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    always_comb begin
        k_d         = k_q;
        base_d      = base_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        mac_en_d    = 1'b0;
        mac_a_d     = '0;
        mac_b_d     = '0;
        coef_d      = coef_q;
        in_ready_d  = (state_d == IDLE);
        case (state_q)
            IDLE: begin
                if (coef_we) coef_d[coef_addr] = coef_wdata;
                if (accept_c) begin
                    base_d = mac_acc;
                    k_d    = '0;
                end
            end
            RUN: begin
                mac_en_d = 1'b1;
                mac_a_d  = tap_sample_c;
                mac_b_d  = coef_q[k_q];
                k_d      = AW'(k_q + 1'b1);
            end
            SETTLE: begin
                if (!mac_en_q) begin
                    out_data_d  = mac_acc - base_q;
                    out_valid_d = 1'b1;
                end
            end
            OUT: begin
                if (out_ready) out_valid_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k_q         <= '0;
            base_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            mac_en_q    <= 1'b0;
            mac_a_q     <= '0;
            mac_b_q     <= '0;
            for (int i = 0; i < int'(NTAPS); i++) coef_q[i] <= '0;
        end else begin
            k_q         <= k_d;
            base_q      <= base_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            mac_en_q    <= mac_en_d;
            mac_a_q     <= mac_a_d;
            mac_b_q     <= mac_b_d;
            coef_q      <= coef_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign mac_en    = mac_en_q;
    assign mac_a     = mac_a_q;
    assign mac_b     = mac_b_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule
